pkt_ff_wctrl: RTL and testbench
===============================

Name: pkt_ff_wctrl

Overview:
- Write-side controller for the async packet FIFO, generalising the single-pointer write logic.
- Generates the RAM write enable and address from a binary write pointer.
- Exports a gray pointer to the read domain that advances only on fully committed packets, so the reader never sees partial or errored packets.
- Detects full against the synchronised read pointer and handles overflow, in-packet error and protocol faults, in either drop mode or backpressure mode.

Parameters:
PTR_W, 8, RAM address width; depth = 2^PTR_W; pointers are PTR_W+1 bits.
DROP_ON_FULL, 1, 1 = drop the packet on overflow; 0 = backpressure via ready.
CNT_W, 16, width of the statistics counters (saturating).

Ports:
clk  in  1  write-domain clock
rst_n  in  1  asynchronous active-low reset
valid  in  1  beat valid
sop  in  1  start of packet (qualified by valid)
eop  in  1  end of packet (qualified by valid)
error  in  1  packet error (qualified by valid)
ready  out  1  beat accepted when valid&ready; tied 1 when DROP_ON_FULL=1
rptr_gry_sync  in  PTR_W+1  read pointer (gray), already synchronised to clk
wr_en  out  1  RAM write strobe (combinational)
waddr  out  PTR_W  RAM write address = wr_ptr[PTR_W-1:0]
wptr_gry  out  PTR_W+1  committed write pointer, gray, registered
full  out  1  wr_ptr - rptr == 2^PTR_W
fill  out  PTR_W+1  wr_ptr - rptr (binary, modulo 2^(PTR_W+1))
drop_cnt  out  CNT_W  packets discarded (error, overflow, missing eop)
pkt_cnt  out  CNT_W  packets committed

Behaviour:
- Reset (async, rst_n=0): wr_ptr=0, commit_ptr=0, wptr_gry=0, drop_cnt=0, pkt_cnt=0, state=IDLE.
  - Outputs after reset: full=0, fill=0, ready=1, wr_en=0.
  - Reset mid-packet discards everything; no partial commit.
- rptr_bin = gray-to-binary of rptr_gry_sync (combinational).
- full and fill are combinational from wr_ptr and rptr_bin.
- ready = DROP_ON_FULL ? 1 : ~full. A beat is "taken" when valid&ready.
- wr_en = taken & (state accepts beat) & ~error & ~full.
  - On a write, wr_ptr increments at the next edge.
  - Wrap: 2^(PTR_W+1)-1 rolls to 0 with no special case.
- Commit: on a taken eop beat written without error:
  - commit_ptr <= wr_ptr+1, wptr_gry <= bin2gray(wr_ptr+1) at the same edge.
  - pkt_cnt++.
  - Read-domain visibility is one cycle after the eop beat, plus synchroniser delay.
- Rewind (wr_ptr <= commit_ptr, drop_cnt++, no write that cycle) occurs on:
  - error on a taken beat in PKT, or on a sop beat in IDLE/DROP;
  - full on a taken beat in PKT or IDLE-sop when DROP_ON_FULL=1;
  - sop received in PKT (missing eop).
- State machine:
  - IDLE:
    - valid&sop, clean write → PKT, or stay IDLE if eop (single-beat packet commits).
    - valid without sop → discard silently; no counter change.
    - sop with error/overflow → DROP, or IDLE if eop.
  - PKT:
    - clean non-eop beat → write, stay PKT.
    - clean eop → commit → IDLE.
    - error/overflow → rewind → IDLE if eop, else DROP.
    - sop → rewind, then restart the packet. The sop beat is written at commit_ptr (wr_en=1, waddr=commit_ptr), wr_ptr <= commit_ptr+1, stay PKT (or commit if eop). Counts one drop.
  - DROP:
    - discard beats until a valid eop → IDLE.
    - valid&sop is handled exactly as in IDLE.
- Counters saturate at 2^CNT_W-1.
- Simultaneous sop&eop&error in IDLE → drop_cnt++, no write, stay IDLE.
- Backpressure mode: valid&~ready beats are not taken, so state is unchanged; upstream must hold the beat.

Test Plan:
- PTR_W=4, rptr static 0; 4-beat packet: sop@addr0, eop@addr3 → wr_en on 4 cycles, waddr 0..3. wptr_gry changes 0→6 (gray of 4) one cycle after eop. pkt_cnt=1, fill=4.
- After the above, a 3-beat packet with error on beat 3 → 2 writes at addr 4,5. wr_ptr rewinds to 4, wptr_gry stays 6, drop_cnt=1. Next packet starts at addr 4.
- DROP_ON_FULL=1, rptr=0: 20-beat packet → writes addr 0..15, full on beat 17, rewind to 0. Beats 18..20 discarded, wptr_gry=0, drop_cnt=1, state IDLE after eop.
- DROP_ON_FULL=0: same 20-beat packet → ready drops after 16 writes. Advance rptr_gry_sync by 4 → ready=1, beats 17..20 written at addr 0..3, commit wptr_gry=bin2gray(20)=30.
- sop at 3rd beat of an unfinished packet (commit_ptr=8) → that sop is written at addr 8, drop_cnt++. The subsequent eop commits.
- Wrap: rptr and commit near 30. A 4-beat packet wraps pointer 30→2 (waddr 14,15,0,1) → wptr_gry=bin2gray(2)=3, fill correct modulo 32.

Source files
------------

// File: rtl/pkt_ff_wctrl.sv
// Write-side controller for the async packet FIFO: RAM write strobe/address,
// committed gray pointer for the reader, full/fill, drop and commit statistics.
module pkt_ff_wctrl #(
  parameter int PTR_W        = 8,
  parameter bit DROP_ON_FULL = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic             sop,
  input  logic             eop,
  input  logic             error,
  output logic             ready,
  input  logic [PTR_W:0]   rptr_gry_sync,
  output logic             wr_en,
  output logic [PTR_W-1:0] waddr,
  output logic [PTR_W:0]   wptr_gry,
  output logic             full,
  output logic [PTR_W:0]   fill,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] pkt_cnt
);

  // state   | meaning
  // IDLE    | between packets, waiting for sop
  // PKT     | writing a packet that is not yet committed
  // DROP    | discarding the rest of a rejected packet until eop
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PKT  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]     state, state_nxt;
  logic [PTR_W:0] wr_ptr, commit_ptr, rptr_bin, wr_base, wr_next;
  logic           taken, bad;
  logic           do_write, do_commit, do_rewind, restart;

  always_comb begin
    rptr_bin = '0;
    for (int i = 0; i <= PTR_W; i++) rptr_bin[i] = ^(rptr_gry_sync >> i);
  end

  assign fill  = wr_ptr - rptr_bin;
  assign full  = (fill == {1'b1, {PTR_W{1'b0}}});
  assign ready = DROP_ON_FULL ? 1'b1 : ~full;
  assign taken = valid & ready;
  assign bad   = error | full;

  always_comb begin
    state_nxt = state;
    do_write  = 1'b0;
    do_commit = 1'b0;
    do_rewind = 1'b0;
    restart   = 1'b0;
    if (taken) begin
      case (state)
        ST_IDLE, ST_DROP: begin
          if (sop) begin
            if (bad) begin
              do_rewind = 1'b1;
              state_nxt = eop ? ST_IDLE : ST_DROP;
            end else begin
              do_write  = 1'b1;
              do_commit = eop;
              state_nxt = eop ? ST_IDLE : ST_PKT;
            end
          end else if (state == ST_DROP && eop) begin
            state_nxt = ST_IDLE;
          end
        end
        ST_PKT: begin
          // A sop mid-packet abandons the open packet and restarts at commit_ptr.
          if (sop) begin
            restart   = 1'b1;
            do_rewind = 1'b1;
          end
          if (bad) begin
            do_rewind = 1'b1;
            state_nxt = eop ? ST_IDLE : ST_DROP;
          end else begin
            do_write  = 1'b1;
            do_commit = eop;
            state_nxt = eop ? ST_IDLE : ST_PKT;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign wr_base = restart ? commit_ptr : wr_ptr;
  assign wr_next = wr_base + (PTR_W+1)'(1);
  assign wr_en   = do_write;
  assign waddr   = wr_base[PTR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      wptr_gry   <= '0;
      drop_cnt   <= '0;
      pkt_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (do_write) wr_ptr <= wr_next;
      else if (do_rewind) wr_ptr <= commit_ptr;
      if (do_commit) begin
        commit_ptr <= wr_next;
        wptr_gry   <= wr_next ^ (wr_next >> 1);
        if (!(&pkt_cnt)) pkt_cnt <= pkt_cnt + CNT_W'(1);
      end
      if (do_rewind && !(&drop_cnt)) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pkt_ff_wctrl.sv
// Bench for pkt_ff_wctrl: a drop-mode and a backpressure-mode instance, with
// expected write strobes/addresses queued per beat and checked as beats are taken.
module tb_pkt_ff_wctrl;
  localparam int PW = 4;

  typedef struct {
    logic       wr;
    logic [3:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        valid_a = 0, sop_a = 0, eop_a = 0, err_a = 0;
  logic        ready_a, wr_en_a, full_a;
  logic [4:0]  rptr_a = '0, wptr_gry_a, fill_a;
  logic [3:0]  waddr_a;
  logic [15:0] drop_cnt_a, pkt_cnt_a;

  logic        valid_b = 0, sop_b = 0, eop_b = 0, err_b = 0;
  logic        ready_b, wr_en_b, full_b;
  logic [4:0]  rptr_b = '0, wptr_gry_b, fill_b;
  logic [3:0]  waddr_b;
  logic [15:0] drop_cnt_b, pkt_cnt_b;

  pkt_ff_wctrl #(.PTR_W(PW), .DROP_ON_FULL(1'b1), .CNT_W(16)) u_drop (
    .clk(clk), .rst_n(rst_n), .valid(valid_a), .sop(sop_a), .eop(eop_a),
    .error(err_a), .ready(ready_a), .rptr_gry_sync(rptr_a), .wr_en(wr_en_a),
    .waddr(waddr_a), .wptr_gry(wptr_gry_a), .full(full_a), .fill(fill_a),
    .drop_cnt(drop_cnt_a), .pkt_cnt(pkt_cnt_a));

  pkt_ff_wctrl #(.PTR_W(PW), .DROP_ON_FULL(1'b0), .CNT_W(16)) u_bp (
    .clk(clk), .rst_n(rst_n), .valid(valid_b), .sop(sop_b), .eop(eop_b),
    .error(err_b), .ready(ready_b), .rptr_gry_sync(rptr_b), .wr_en(wr_en_b),
    .waddr(waddr_b), .wptr_gry(wptr_gry_b), .full(full_b), .fill(fill_b),
    .drop_cnt(drop_cnt_b), .pkt_cnt(pkt_cnt_b));

  int checks = 0;
  int failures = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic [4:0] a_ptr = '0;
  int exp_pkt_a = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] to_gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  always @(negedge clk) begin
    exp_t x;
    if (valid_a) begin
      if (qa.size() == 0) check_eq("sb_a_empty", 1, 0);
      else begin
        x = qa.pop_front();
        check_eq("wr_en_a", wr_en_a, x.wr);
        if (x.wr) check_eq("waddr_a", waddr_a, x.addr);
      end
    end
    if (valid_b && ready_b) begin
      if (qb.size() == 0) check_eq("sb_b_empty", 1, 0);
      else begin
        x = qb.pop_front();
        check_eq("wr_en_b", wr_en_b, x.wr);
        if (x.wr) check_eq("waddr_b", waddr_b, x.addr);
      end
    end else if (valid_b) begin
      check_eq("wr_en_b_held", wr_en_b, 0);
    end
  end

  task automatic beat_a(input logic s, input logic e, input logic er,
                        input logic ew, input logic [3:0] ea);
    exp_t x;
    x.wr = ew; x.addr = ea;
    qa.push_back(x);
    valid_a = 1; sop_a = s; eop_a = e; err_a = er;
    @(posedge clk); #1;
    valid_a = 0; sop_a = 0; eop_a = 0; err_a = 0;
  endtask

  // Clean n-beat packet at the model pointer; commit expected on eop.
  task automatic pkt_a(input int n);
    for (int i = 0; i < n; i++)
      beat_a(i == 0, i == n - 1, 1'b0, 1'b1, 4'(a_ptr + 5'(i)));
    a_ptr = a_ptr + 5'(n);
    exp_pkt_a++;
    check_eq("pkt_wptr_gry_a", wptr_gry_a, to_gray(a_ptr));
    check_eq("pkt_cnt_a", pkt_cnt_a, exp_pkt_a);
  endtask

  task automatic beat_b(input logic s, input logic e, input logic [3:0] ea);
    exp_t x;
    bit ok = 0;
    x.wr = 1'b1; x.addr = ea;
    qb.push_back(x);
    valid_b = 1; sop_b = s; eop_b = e; err_b = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (ready_b) ok = 1;
      @(posedge clk); #1;
    end
    if (!ok) check_eq("beat_b_timeout", 0, 1);
    valid_b = 0; sop_b = 0; eop_b = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_full", full_a, 0);
    check_eq("rst_fill", fill_a, 0);
    check_eq("rst_ready_b", ready_b, 1);
    check_eq("rst_wr_en", wr_en_a, 0);
    check_eq("rst_wptr_gry", wptr_gry_a, 0);
    check_eq("rst_cnts", {drop_cnt_a, pkt_cnt_a}, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // 4-beat packet at 0..3, committed pointer 4 (gray 6)
    for (int i = 0; i < 3; i++) beat_a(i == 0, 1'b0, 1'b0, 1'b1, 4'(i));
    check_eq("precommit_gry", wptr_gry_a, 0);
    beat_a(1'b0, 1'b1, 1'b0, 1'b1, 4'd3);
    a_ptr = 5'd4; exp_pkt_a = 1;
    check_eq("t1_wptr_gry", wptr_gry_a, 6);
    check_eq("t1_pkt_cnt", pkt_cnt_a, 1);
    check_eq("t1_fill", fill_a, 4);

    // error on the eop beat: rewind to 4, no commit
    beat_a(1'b1, 1'b0, 1'b0, 1'b1, 4'd4);
    beat_a(1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
    beat_a(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    check_eq("t2_wptr_gry", wptr_gry_a, 6);
    check_eq("t2_drop_cnt", drop_cnt_a, 1);
    check_eq("t2_fill", fill_a, 4);
    pkt_a(2);

    // sop inside an open packet restarts at commit_ptr 6
    beat_a(1'b1, 1'b0, 1'b0, 1'b1, 4'd6);
    beat_a(1'b0, 1'b0, 1'b0, 1'b1, 4'd7);
    beat_a(1'b1, 1'b0, 1'b0, 1'b1, 4'd6);
    check_eq("t3_drop_cnt", drop_cnt_a, 2);
    beat_a(1'b0, 1'b1, 1'b0, 1'b1, 4'd7);
    a_ptr = 5'd8; exp_pkt_a++;
    check_eq("t3_wptr_gry", wptr_gry_a, to_gray(5'd8));
    check_eq("t3_pkt_cnt", pkt_cnt_a, exp_pkt_a);

    // march pointers up to 30, then wrap 30 -> 2
    rptr_a = to_gray(5'd8);
    pkt_a(4); pkt_a(4); pkt_a(4);
    check_eq("fill_12", fill_a, 12);
    rptr_a = to_gray(5'd20);
    pkt_a(4); pkt_a(4); pkt_a(2);
    rptr_a = to_gray(5'd30);
    pkt_a(4);
    check_eq("wrap_wptr_gry", wptr_gry_a, 3);
    check_eq("wrap_fill", fill_a, 4);

    // overflow in drop mode: 16 writes, beat 17 full -> rewind, rest discarded
    rptr_a = to_gray(5'd2);
    for (int i = 1; i <= 16; i++) beat_a(i == 1, 1'b0, 1'b0, 1'b1, 4'(5'd2 + 5'(i - 1)));
    check_eq("ovf_full", full_a, 1);
    check_eq("ovf_ready_a", ready_a, 1);
    for (int i = 17; i <= 20; i++) beat_a(1'b0, i == 20, 1'b0, 1'b0, 4'd0);
    check_eq("ovf_drop_cnt", drop_cnt_a, 3);
    check_eq("ovf_wptr_gry", wptr_gry_a, 3);
    check_eq("ovf_fill", fill_a, 0);

    // sop+eop+error in IDLE, stray non-sop beat, then single-beat packet
    beat_a(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    check_eq("see_drop_cnt", drop_cnt_a, 4);
    beat_a(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    check_eq("stray_drop_cnt", drop_cnt_a, 4);
    pkt_a(1);

    // errored non-eop beat -> DROP; a sop in DROP starts cleanly
    beat_a(1'b1, 1'b0, 1'b0, 1'b1, 4'd3);
    beat_a(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    beat_a(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    check_eq("drop_drop_cnt", drop_cnt_a, 5);
    pkt_a(1);
    check_eq("drop_wptr_gry", wptr_gry_a, 6);

    // backpressure: 16 writes, stall, free 4 entries, finish 20-beat packet
    for (int i = 1; i <= 16; i++) beat_b(i == 1, 1'b0, 4'(i - 1));
    check_eq("bp_ready_low", ready_b, 0);
    check_eq("bp_full", full_b, 1);
    x.wr = 1'b1; x.addr = 4'd0;
    qb.push_back(x);
    valid_b = 1;
    repeat (3) begin @(posedge clk); #1; end
    check_eq("bp_stall_fill", fill_b, 16);
    rptr_b = to_gray(5'd4);
    #1;
    check_eq("bp_ready_high", ready_b, 1);
    @(posedge clk); #1;
    valid_b = 0;
    for (int i = 18; i <= 20; i++) beat_b(1'b0, i == 20, 4'(i - 17));
    check_eq("bp_wptr_gry", wptr_gry_b, 30);
    check_eq("bp_pkt_cnt", pkt_cnt_b, 1);
    check_eq("bp_fill", fill_b, 16);
    check_eq("bp_drop_cnt", drop_cnt_b, 0);

    // reset in the middle of a packet discards it
    beat_a(1'b1, 1'b0, 1'b0, 1'b1, 4'd4);
    rptr_a = '0; rptr_b = '0;
    rst_n = 0;
    #2;
    check_eq("mid_rst_wptr_gry", wptr_gry_a, 0);
    check_eq("mid_rst_fill", fill_a, 0);
    check_eq("mid_rst_cnts", {drop_cnt_a, pkt_cnt_a}, 0);
    check_eq("mid_rst_ready_b", ready_b, 1);
    check_eq("mid_rst_gry_b", wptr_gry_b, 0);
    rst_n = 1;
    @(posedge clk); #1;

    check_eq("qa_drained", qa.size(), 0);
    check_eq("qb_drained", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
